pc_unit: RTL and testbench

Program-counter and instruction-fetch sequencer for the single-cycle MIPS core. It sits upstream of the `control` decoder. It fetches each instruction from instruction memory over a req/ack handshake and presents it, with the registered interrupt request, to `control`. It then consumes the decoded `PCSrc` selection to compute the next PC, including the supervisor-bit rules and the interrupt/exception vectors.

---
 rtl/pc_unit.sv | 121 ++++++++++++
 tb/tb_pc_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter and two-state fetch/execute sequencer for the single-cycle MIPS core.
// Define PC_IRQ_SYNC_EN to pass IRQ_in through a 2-flop synchronizer before irq_pend.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
  parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSrc,
  input  logic        ALUOut0,
  input  logic [31:0] ConBA,
  input  logic [25:0] JT,
  input  logic [31:0] DatabusA,
  input  logic        IRQ_in,
  output logic        IRQ,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruct,
  output logic        instr_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_plus_4
);

  typedef enum logic [0:0] {StFetch, StExec} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] next_pc;
  logic        irq_pend_q;
  logic        irq_src;

  // ConBA[31] is replaced by the current supervisor bit, so it is never read.
  logic unused_conba_msb;
  assign unused_conba_msb = ConBA[31];

`ifdef PC_IRQ_SYNC_EN
  logic [1:0] irq_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_sync_q <= '0;
    end else begin
      irq_sync_q <= {irq_sync_q[0], IRQ_in};
    end
  end

  assign irq_src = irq_sync_q[1];
`else
  assign irq_src = IRQ_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_pend_q <= 1'b0;
    end else begin
      irq_pend_q <= irq_src;
    end
  end

  // Supervisor mode (PC[31]) masks interrupts.
  assign IRQ = irq_pend_q & ~pc_q[31];

  // Increment stays within the low 31 bits; the supervisor bit is carried over untouched.
  assign PC_plus_4 = {pc_q[31], pc_q[30:0] + 31'd4};

  always_comb begin
    next_pc = PC_plus_4;
    case (PCSrc)
      3'd0: next_pc = PC_plus_4;
      3'd1: next_pc = ALUOut0 ? {pc_q[31], ConBA[30:0]} : PC_plus_4;
      3'd2: next_pc = {pc_q[31:28], JT, 2'b00};
      // A jump register can only clear the supervisor bit, never set it.
      3'd3: next_pc = {pc_q[31] & DatabusA[31], DatabusA[30:0]};
      3'd4: next_pc = ILLOP_PC;
      default: next_pc = XADR_PC;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StExec;
        end
      end
      StExec: begin
        instr_valid = 1'b1;
        pc_d        = next_pc;
        state_d     = StFetch;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign imem_addr = pc_q;
  assign instruct  = instr_q;
  assign PC        = pc_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: randomized fetch/execute traffic against a PC model,
// with a scoreboard monitor that checks every executed instruction.
module tb_pc_unit;

  localparam logic [31:0] RstPc   = 32'h8000_0000;
  localparam logic [31:0] IllopPc = 32'h8000_0004;
  localparam logic [31:0] XadrPc  = 32'h8000_0008;
`ifdef PC_IRQ_SYNC_EN
  localparam int IrqLat = 3;
`else
  localparam int IrqLat = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  PCSrc;
  logic        ALUOut0;
  logic [31:0] ConBA;
  logic [25:0] JT;
  logic [31:0] DatabusA;
  logic        IRQ_in;
  logic        IRQ;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruct;
  logic        instr_valid;
  logic [31:0] PC;
  logic [31:0] PC_plus_4;

  pc_unit dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrc      (PCSrc),
    .ALUOut0    (ALUOut0),
    .ConBA      (ConBA),
    .JT         (JT),
    .DatabusA   (DatabusA),
    .IRQ_in     (IRQ_in),
    .IRQ        (IRQ),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instruct   (instruct),
    .instr_valid(instr_valid),
    .PC         (PC),
    .PC_plus_4  (PC_plus_4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] plus4;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_pc;
  bit          chk_en    = 0;
  bit          irq_rand  = 0;
  bit          irq_force = 0;
  logic [2:0]  irq_hist;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_plus4(input logic [31:0] pc);
    return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7fff_ffff);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc, input logic [2:0] src,
                                         input logic alu, input logic [31:0] conba,
                                         input logic [25:0] jt, input logic [31:0] dba);
    logic [31:0] sup;
    sup = pc & 32'h8000_0000;
    if (src == 3'd0 || (src == 3'd1 && !alu)) return m_plus4(pc);
    if (src == 3'd1) return sup | (conba & 32'h7fff_ffff);
    if (src == 3'd2) return (pc & 32'hf000_0000) | ({6'd0, jt} * 4);
    if (src == 3'd3) return (sup & dba) | (dba & 32'h7fff_ffff);
    if (src == 3'd4) return IllopPc;
    return XadrPc;
  endfunction

  // Reference history of IRQ_in as seen at each clock edge; index 0 is the most recent.
  always @(posedge clk) begin
    if (reset) irq_hist <= '0;
    else       irq_hist <= {irq_hist[1:0], IRQ_in};
  end

  always @(negedge clk) begin
    if (chk_en && !reset)
      check("irq", {31'd0, IRQ}, {31'd0, irq_hist[IrqLat-1] & ~model_pc[31]});
  end

  // Scoreboard monitor: every instr_valid pulse consumes exactly one expected entry.
  always @(negedge clk) begin
    if (chk_en && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_instr_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("exec_instruct", instruct, e.instr);
        check("exec_pc", PC, e.pc);
        check("exec_pc_plus_4", PC_plus_4, e.plus4);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    IRQ_in = irq_rand ? 1'($urandom_range(0, 1)) : irq_force;
  end

  // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 back in FETCH.
  task automatic do_instr(input int w, input logic [31:0] rdata, input logic [2:0] src,
                          input logic alu, input logic [31:0] conba, input logic [25:0] jt,
                          input logic [31:0] dba, input bit rst_exec);
    for (int i = 0; i < w; i++) begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      @(negedge clk);
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_addr", imem_addr, model_pc);
      check("wait_pc", PC, model_pc);
      check("wait_valid", {31'd0, instr_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    PCSrc      = src;
    ALUOut0    = alu;
    ConBA      = conba;
    JT         = jt;
    DatabusA   = dba;
    exp_q.push_back('{pc: model_pc, plus4: m_plus4(model_pc), instr: rdata});
    @(negedge clk);
    check("ack_req", {31'd0, imem_req}, 32'd1);
    check("ack_addr", imem_addr, model_pc);
    @(posedge clk);
    #1;
    // A stray ack during execute must be ignored.
    imem_ack   = 1'($urandom_range(0, 1));
    imem_rdata = $urandom;
    if (rst_exec) reset = 1'b1;
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    if (rst_exec) begin
      reset    = 1'b0;
      model_pc = RstPc;
      check("rst_exec_pc", PC, RstPc);
      check("rst_exec_valid", {31'd0, instr_valid}, 32'd0);
      check("rst_exec_instruct", instruct, 32'd0);
    end else begin
      model_pc = m_next(model_pc, src, alu, conba, jt, dba);
    end
  endtask

  task automatic jr(input logic [31:0] dba);
    do_instr(0, $urandom, 3'd3, 1'b0, 32'd0, 26'd0, dba, 0);
  endtask

  initial begin
    reset      = 1'b1;
    PCSrc      = '0;
    ALUOut0    = 1'b0;
    ConBA      = '0;
    JT         = '0;
    DatabusA   = '0;
    IRQ_in     = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    model_pc   = RstPc;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", PC, RstPc);
    check("rst_instruct", instruct, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd1);
    reset  = 1'b0;
    chk_en = 1;

    // First fetch with zero-wait ack, then sequential PC+4.
    do_instr(0, 32'h2008_0005, 3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 0);
    check("seq_addr", model_pc, 32'h8000_0004);
    // Three wait states while jumping to 0x100.
    do_instr(3, $urandom, 3'd3, 1'b0, 32'd0, 26'd0, 32'h0000_0100, 0);
    // Branch taken from 0x100, back to 0x100, then branch not taken.
    do_instr(0, $urandom, 3'd1, 1'b1, 32'h0000_0200, 26'd0, 32'd0, 0);
    check("br_taken", model_pc, 32'h0000_0200);
    jr(32'h0000_0100);
    do_instr(0, $urandom, 3'd1, 1'b0, 32'h0000_0200, 26'd0, 32'd0, 0);
    check("br_not_taken", model_pc, 32'h0000_0104);
    // User-mode jr cannot set the supervisor bit.
    jr(32'h0000_0040);
    jr(32'h8000_1000);
    check("jr_user", model_pc, 32'h0000_1000);
    do_instr(0, $urandom, 3'd4, 1'b0, 32'd0, 26'd0, 32'd0, 0);
    jr(32'h8000_0040);
    jr(32'h0000_2000);
    check("jr_sup", model_pc, 32'h0000_2000);
    do_instr(1, $urandom, 3'd2, 1'b0, 32'd0, 26'h3ab_cdef, 32'd0, 0);
    do_instr(0, $urandom, 3'd6, 1'b0, 32'd0, 26'd0, 32'd0, 0);

    // Interrupt at user PC 0x10, vector taken, IRQ masked once back in supervisor.
    jr(32'h0000_0010);
    irq_force = 1;
    do_instr(3, $urandom, 3'd4, 1'b0, 32'd0, 26'd0, 32'd0, 0);
    check("irq_vector", model_pc, IllopPc);
    do_instr(2, $urandom, 3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 0);
    irq_force = 0;

    // Reset while waiting for an ack.
    imem_ack = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    model_pc = RstPc;
    check("rst_fetch_pc", PC, RstPc);
    check("rst_fetch_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_fetch_req", {31'd0, imem_req}, 32'd1);
    check("rst_fetch_instruct", instruct, 32'd0);

    // Reset during execute suppresses the PC update.
    jr(32'h0000_0300);
    do_instr(0, $urandom, 3'd0, 1'b0, 32'd0, 26'd0, 32'd0, 1);

    irq_rand = 1;
    for (int n = 0; n < 200; n++) begin
      do_instr($urandom_range(0, 3), $urandom, 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), $urandom, 26'($urandom), $urandom,
               ($urandom_range(0, 49) == 0));
    end
    irq_rand = 0;

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
